dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Arbitrates the single local DMEM port between the core load/store path and incoming remote network requests. Core requests win by default; a starvation counter forces a remote grant after a bounded number of denied cycles. Tracks the read-response owner for the one-cycle DMEM read latency and maintains the load-reserved reservation, breaking it when a granted remote store hits the reserved word. Sits between the core LSU, the network RX endpoint and the DMEM macro.

## Interface
- data_width_p, 32, word width; mask width is data_width_p/8
- dmem_size_p, 1024, DMEM depth in words; addr width aw = clog2(dmem_size_p), minimum 1
- starve_limit_p, 4, denied remote cycles before forced remote grant; legal range 1..255

- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- core_v_i / core_w_i  in  1 / 1  core request valid / write
- core_addr_i  in  aw  core word address
- core_data_i / core_mask_i  in  data_width_p / data_width_p/8  core write data / byte mask
- core_reserve_i  in  1  core read is load-reserved
- core_clear_reserve_i  in  1  core drops its reservation
- core_yumi_o  out  1  core request accepted this cycle
- core_rdata_v_o / core_rdata_o  out  1 / data_width_p  core read response
- remote_v_i / remote_w_i  in  1 / 1  remote request valid / write
- remote_addr_i, remote_data_i, remote_mask_i  in  aw / data_width_p / data_width_p/8  remote request
- remote_yumi_o  out  1  remote request accepted this cycle
- remote_rdata_v_o / remote_rdata_o  out  1 / data_width_p  remote read response
- mem_v_o / mem_w_o  out  1 / 1  DMEM enable / write
- mem_addr_o, mem_data_o, mem_mask_o  out  aw / data_width_p / data_width_p/8  DMEM command
- mem_rdata_i  in  data_width_p  DMEM read data, valid one cycle after a read
- reserve_v_o / reserve_addr_o  out  1 / aw  reservation state
- break_reserve_o  out  1  one-cycle pulse: reservation broken by remote store

## Operation
- Grant, combinational: sel_remote = remote_v_i & (~core_v_i | starved). core_yumi_o = core_v_i & ~sel_remote; remote_yumi_o = sel_remote. At most one yumi per cycle.
- starved = (starve_cnt == starve_limit_p). starve_cnt (8 bits): increments when remote_v_i & ~remote_yumi_o, saturating at starve_limit_p; clears to 0 on remote_yumi_o; holds otherwise (including remote_v_i low).
- Mux: mem_v_o = either yumi; mem_w_o, addr, data, mask taken from the granted side; all-zero mask/data when idle.
- Response owner: registers rd_core_r = core_yumi_o & ~core_w_i and rd_remote_r = remote_yumi_o & ~remote_w_i. core_rdata_v_o = rd_core_r, remote_rdata_v_o = rd_remote_r; both rdata outputs = mem_rdata_i passthrough, zero when their valid is low.
- Reservation register (reserve_v_r, reserve_addr_r):
  - granted core read with core_reserve_i: set, capture core_addr_i (overwrites any existing reservation).
  - granted remote write with remote_addr_i == reserve_addr_r while reserve_v_r: clear; break_reserve_o = 1 next cycle.
  - core_clear_reserve_i: clear, no break pulse.
  - same-cycle set and clear_reserve: set wins. Remote store cannot coincide with core set (single grant).
- Granted core writes never break the reservation.

## Timing
- Reset (async assert, sync to clk_i on release): starve_cnt = 0, rd_core_r = rd_remote_r = 0, reserve_v_r = 0, reserve_addr_r = 0, break_reserve_o = 0. Outputs at reset: all valids/yumis 0 unless inputs request (yumis are combinational from valids and starve_cnt = 0).
- Grant latency 0 cycles; read response exactly 1 cycle after grant; no stalls, no buffering.
- Back-to-back reads from alternating owners deliver responses in grant order, one per cycle.
- Reset asserted mid-operation drops any in-flight response valid; reservation lost.

## Test plan
- Reset: hold reset_n_i low, drive core_v_i=1 read -> after release, core_yumi_o=1 same cycle, core_rdata_v_o=1 next cycle, reserve_v_o=0, break_reserve_o=0.
- Starvation, starve_limit_p=4: core_v_i and remote_v_i held high -> core granted cycles 0-3, remote granted cycle 4, starve_cnt back to 0, core granted cycles 5-8, remote cycle 9.
- Remote alone: remote_v_i=1 read addr 0x10, core idle -> remote_yumi_o=1 immediately, mem_addr_o=0x10, remote_rdata_v_o=1 next cycle with mem_rdata_i value; core_rdata_v_o=0.
- Reservation break: core LR to 0x20 -> reserve_v_o=1, reserve_addr_o=0x20; remote store to 0x20 granted -> reserve_v_o=0 and break_reserve_o=1 for exactly one cycle.
- No-break cases: reservation on 0x20; remote store to 0x21 -> reservation held; core store to 0x20 -> held; core_clear_reserve_i -> cleared, break_reserve_o stays 0.
- Async reset mid-read: grant core read, assert reset_n_i before next edge -> core_rdata_v_o=0 immediately, starve_cnt=0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares the single local DMEM port between the core load/store
//            path and remote network requests. The core wins by default. A
//            starvation counter forces a remote grant once the remote side
//            has been refused starve_limit_p times. The block records which
//            side owns the read response (DMEM has one-cycle read latency).
//            It also holds the load-reserved reservation, which a granted
//            remote store to the reserved word breaks.
// Ports    : clk_i, reset_n_i          clock, async active-low reset
//            core_*_i / core_*_o       core LSU request, accept, read response
//            remote_*_i / remote_*_o   network RX request, accept, response
//            mem_*_o / mem_rdata_i     DMEM macro command and read data
//            reserve_v_o/_addr_o       current reservation
//            break_reserve_o           one-cycle pulse on a remote break
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter  int data_width_p   = 32,
  parameter  int dmem_size_p    = 1024,
  parameter  int starve_limit_p = 4,
  localparam int aw_lp          = (dmem_size_p > 1) ? $clog2(dmem_size_p) : 1,
  localparam int mask_width_lp  = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     core_v_i,
  input  logic                     core_w_i,
  input  logic [aw_lp-1:0]         core_addr_i,
  input  logic [data_width_p-1:0]  core_data_i,
  input  logic [mask_width_lp-1:0] core_mask_i,
  input  logic                     core_reserve_i,
  input  logic                     core_clear_reserve_i,
  output logic                     core_yumi_o,
  output logic                     core_rdata_v_o,
  output logic [data_width_p-1:0]  core_rdata_o,

  input  logic                     remote_v_i,
  input  logic                     remote_w_i,
  input  logic [aw_lp-1:0]         remote_addr_i,
  input  logic [data_width_p-1:0]  remote_data_i,
  input  logic [mask_width_lp-1:0] remote_mask_i,
  output logic                     remote_yumi_o,
  output logic                     remote_rdata_v_o,
  output logic [data_width_p-1:0]  remote_rdata_o,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [aw_lp-1:0]         mem_addr_o,
  output logic [data_width_p-1:0]  mem_data_o,
  output logic [mask_width_lp-1:0] mem_mask_o,
  input  logic [data_width_p-1:0]  mem_rdata_i,

  output logic                     reserve_v_o,
  output logic [aw_lp-1:0]         reserve_addr_o,
  output logic                     break_reserve_o
);

  localparam logic [7:0] starve_limit_lp = 8'(starve_limit_p);

  logic [7:0]       starve_cnt;
  logic             starved;
  logic             sel_remote;
  logic             rd_core_r;
  logic             rd_remote_r;
  logic             reserve_v_r;
  logic [aw_lp-1:0] reserve_addr_r;
  logic             break_r;
  logic             res_set;
  logic             res_hit;

  // Grant: the remote side gets the port when the core is idle, or when the
  // remote side has been refused enough times.
  assign starved       = (starve_cnt == starve_limit_lp);
  assign sel_remote    = remote_v_i & (~core_v_i | starved);
  assign core_yumi_o   = core_v_i & ~sel_remote;
  assign remote_yumi_o = sel_remote;

  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    mem_mask_o = '0;
    if (sel_remote) begin
      mem_v_o    = 1'b1;
      mem_w_o    = remote_w_i;
      mem_addr_o = remote_addr_i;
      mem_data_o = remote_data_i;
      mem_mask_o = remote_mask_i;
    end else if (core_v_i) begin
      mem_v_o    = 1'b1;
      mem_w_o    = core_w_i;
      mem_addr_o = core_addr_i;
      mem_data_o = core_data_i;
      mem_mask_o = core_mask_i;
    end
  end

  // A reservation is set only by a granted core load-reserved read. It is
  // broken only by a granted remote store to the reserved word. The core
  // and remote grants are exclusive, so both cannot fire in the same cycle.
  assign res_set = core_yumi_o & ~core_w_i & core_reserve_i;
  assign res_hit = remote_yumi_o & remote_w_i & reserve_v_r
                   & (remote_addr_i == reserve_addr_r);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt     <= 8'd0;
      rd_core_r      <= 1'b0;
      rd_remote_r    <= 1'b0;
      reserve_v_r    <= 1'b0;
      reserve_addr_r <= '0;
      break_r        <= 1'b0;
    end else begin
      // Saturating count of refused remote cycles
      if (remote_yumi_o) begin
        starve_cnt <= 8'd0;
      end else if (remote_v_i && (starve_cnt != starve_limit_lp)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end

      rd_core_r   <= core_yumi_o & ~core_w_i;
      rd_remote_r <= remote_yumi_o & ~remote_w_i;
      break_r     <= res_hit;

      // A set wins over a same-cycle clear request from the core
      if (res_set) begin
        reserve_v_r    <= 1'b1;
        reserve_addr_r <= core_addr_i;
      end else if (res_hit || core_clear_reserve_i) begin
        reserve_v_r    <= 1'b0;
      end
    end
  end

  assign core_rdata_v_o   = rd_core_r;
  assign remote_rdata_v_o = rd_remote_r;
  assign core_rdata_o     = rd_core_r   ? mem_rdata_i : '0;
  assign remote_rdata_o   = rd_remote_r ? mem_rdata_i : '0;

  assign reserve_v_o      = reserve_v_r;
  assign reserve_addr_o   = reserve_addr_r;
  assign break_reserve_o  = break_r;

endmodule
`default_nettype wire
